// File: rtl/result_drain_pkg.sv
// Shared types and sizing helpers for the results-SRAM drain streamer.
package result_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_STREAM,
    ST_FIN
  } drain_state_e;

  // Default lane-slice width: one signed partial sum.
  localparam int DEFAULT_LANE_W = 24;

  function automatic int beats_per_row(input int matrix_size, input int lanes_per_beat);
    return matrix_size / lanes_per_beat;
  endfunction

  function automatic int beat_width(input int lane_w, input int lanes_per_beat);
    return lane_w * lanes_per_beat;
  endfunction

endpackage

// File: rtl/row_beat_serializer.sv
// Row register(s), beat counter and lane mux for the drain streamer.
// RESULT_DRAIN_PREFETCH_EN adds a second row register used as a ping-pong buffer.
module row_beat_serializer
  import result_drain_pkg::*;
#(
  parameter int MATRIX_SIZE    = 32,
  parameter int PARTIAL_SUM_BW = DEFAULT_LANE_W,
  parameter int LANES_PER_BEAT = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cap_en,
`ifdef RESULT_DRAIN_PREFETCH_EN
  input  logic                                   cap_alt,
  input  logic                                   swap,
`endif
  input  logic                                   fire,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  rd_data,
  output logic                                   beat_last,
  output logic [PARTIAL_SUM_BW*LANES_PER_BEAT-1:0] out_data
);

  localparam int BPR    = beats_per_row(MATRIX_SIZE, LANES_PER_BEAT);
  localparam int BEAT_W = beat_width(PARTIAL_SUM_BW, LANES_PER_BEAT);
  localparam int ROW_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int CNT_W  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(BPR - 1);

  logic [CNT_W-1:0]           beat_q, beat_d;
  logic [ROW_W-1:0]           cur_row;
  logic [BPR-1:0][BEAT_W-1:0] beats;

`ifdef RESULT_DRAIN_PREFETCH_EN
  logic [1:0][ROW_W-1:0] buf_q, buf_d;
  logic                  act_q, act_d;

  always_comb begin
    buf_d = buf_q;
    act_d = act_q;
    if (cap_en)  buf_d[act_q]  = rd_data;
    if (cap_alt) buf_d[~act_q] = rd_data;
    if (swap)    act_d = ~act_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      act_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      act_q <= act_d;
    end
  end

  assign cur_row = buf_q[act_q];
`else
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    if (cap_en) row_d = rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) row_q <= '0;
    else     row_q <= row_d;
  end

  assign cur_row = row_q;
`endif

  // Beat counter wraps at the row end so every row starts from beat 0.
  always_comb begin
    beat_d = beat_q;
    if (cap_en) beat_d = '0;
    if (fire)   beat_d = beat_last ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_q <= '0;
    else     beat_q <= beat_d;
  end

  assign beat_last = (beat_q == BEAT_MAX);
  assign beats     = cur_row;
  assign out_data  = beats[beat_q];

endmodule

// File: rtl/result_drain_streamer.sv
// Walks the results SRAM row by row and serializes each row onto a valid/ready stream.
// RESULT_DRAIN_PREFETCH_EN overlaps the next row fetch with streaming of the current row.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | rd_address holds base+row
// CAPTURE | SRAM data valid, loaded into the row register
// STREAM  | beats presented to the sink
// FIN     | one-cycle done pulse
module result_drain_streamer
  import result_drain_pkg::*;
#(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 32,
  parameter int PARTIAL_SUM_BW = DEFAULT_LANE_W,
  parameter int LANES_PER_BEAT = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [ADDRESSSIZE-1:0]                   base_addr,
  output logic [ADDRESSSIZE-1:0]                   rd_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]    rd_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [PARTIAL_SUM_BW*LANES_PER_BEAT-1:0] out_data,
  output logic [ADDRESSSIZE-1:0]                   out_row,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     done
);

  localparam logic [ADDRESSSIZE-1:0] LAST_ROW = ADDRESSSIZE'(MATRIX_SIZE - 1);

  drain_state_e           state_q, state_d;
  logic [ADDRESSSIZE-1:0] base_q, base_d, row_q, row_d, rd_address_q, rd_address_d;
  logic [ADDRESSSIZE-1:0] next_addr;
  logic                   cap_en, fire, beat_last, final_row;

  assign fire      = (state_q == ST_STREAM) && out_ready;
  assign final_row = (row_q == LAST_ROW);
  assign next_addr = base_q + row_q + ADDRESSSIZE'(1);

`ifdef RESULT_DRAIN_PREFETCH_EN
  // Prefetch pipe: 0 none, 1 address out, 2 data valid, 3 row buffered.
  logic [1:0] pf_q, pf_d;
  logic       cap_alt, swap;
`endif

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    row_d        = row_q;
    rd_address_d = rd_address_q;
    cap_en       = 1'b0;
`ifdef RESULT_DRAIN_PREFETCH_EN
    pf_d    = pf_q;
    cap_alt = 1'b0;
    swap    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_FETCH;
          base_d       = base_addr;
          row_d        = '0;
          rd_address_d = base_addr;
`ifdef RESULT_DRAIN_PREFETCH_EN
          pf_d = 2'd0;
`endif
        end
      end
      ST_FETCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        cap_en  = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
`ifdef RESULT_DRAIN_PREFETCH_EN
        if (pf_q == 2'd2) begin
          cap_alt = 1'b1;
          pf_d    = 2'd3;
        end else if (pf_q == 2'd1) begin
          pf_d = 2'd2;
        end else if (pf_q == 2'd0 && !final_row) begin
          rd_address_d = next_addr;
          pf_d         = 2'd1;
        end
`endif
        if (fire && beat_last) begin
          if (final_row) begin
            state_d = ST_FIN;
          end else begin
            row_d = row_q + ADDRESSSIZE'(1);
`ifdef RESULT_DRAIN_PREFETCH_EN
            pf_d = 2'd0;
            if (pf_q == 2'd3) begin
              swap = 1'b1;
            end else begin
              // Next row not ready yet (very short rows): fall back to a plain fetch.
              cap_alt      = 1'b0;
              rd_address_d = next_addr;
              state_d      = ST_FETCH;
            end
`else
            rd_address_d = next_addr;
            state_d      = ST_FETCH;
`endif
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      row_q        <= '0;
      rd_address_q <= '0;
`ifdef RESULT_DRAIN_PREFETCH_EN
      pf_q         <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      row_q        <= row_d;
      rd_address_q <= rd_address_d;
`ifdef RESULT_DRAIN_PREFETCH_EN
      pf_q         <= pf_d;
`endif
    end
  end

  row_beat_serializer #(
    .MATRIX_SIZE   (MATRIX_SIZE),
    .PARTIAL_SUM_BW(PARTIAL_SUM_BW),
    .LANES_PER_BEAT(LANES_PER_BEAT)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
`ifdef RESULT_DRAIN_PREFETCH_EN
    .cap_alt  (cap_alt),
    .swap     (swap),
`endif
    .fire     (fire),
    .rd_data  (rd_data),
    .beat_last(beat_last),
    .out_data (out_data)
  );

  assign rd_address = rd_address_q;
  assign out_valid  = (state_q == ST_STREAM);
  assign out_row    = row_q;
  assign out_last   = out_valid && final_row && beat_last;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);

endmodule

// File: tb/tb_result_drain_streamer.sv
// Randomized bench for result_drain_streamer against a row/beat reference model.
module tb_result_drain_streamer;

  localparam int AW   = 10;
  localparam int MS   = 32;
  localparam int BW   = 24;
  localparam int L    = 4;
  localparam int BPR  = MS / L;
  localparam int NB   = MS * BPR;
  localparam int BEAT_W = BW * L;
`ifdef RESULT_DRAIN_PREFETCH_EN
  localparam int EXP_DONE = 3 + NB;
`else
  localparam int EXP_DONE = 1 + MS * (BPR + 2);
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [AW-1:0]        rd_address;
  logic [BW*MS-1:0]     rd_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [BEAT_W-1:0]    out_data;
  logic [AW-1:0]        out_row;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] lane_mem [1024][MS];

  result_drain_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .rd_address(rd_address),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // SRAM with one cycle of read latency.
  always @(posedge clk)
    for (int j = 0; j < MS; j++) rd_data[j*BW +: BW] <= lane_mem[rd_address][j];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < 1024; a++)
      for (int j = 0; j < MS; j++) lane_mem[a][j] = BW'(a * MS + j);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 1024; a++)
      for (int j = 0; j < MS; j++) lane_mem[a][j] = BW'($urandom);
  endtask

  function automatic logic [BEAT_W-1:0] exp_beat(input logic [AW-1:0] base, input int n);
    logic [AW-1:0]     a;
    logic [BEAT_W-1:0] v;
    int                k;
    a = AW'(base + n / BPR);
    k = n % BPR;
    for (int j = 0; j < L; j++) v[j*BW +: BW] = lane_mem[a][k*L + j];
    return v;
  endfunction

  task automatic check_reset_vals();
    chk("rst_rd_address", rd_address, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  // Entered and left just after a rising edge.
  task automatic run_drain(input logic [AW-1:0] base, input bit rnd, input bit pulses, input int abort_at);
    int                cyc = 0, nbeat = 0, ndone = 0, first_v = 0, last_hs = 0, done_cyc = 0, naddr = 0;
    bit                fin = 0, aborted = 0, prev_stall = 0;
    logic [BEAT_W-1:0] prev_data = '0;
    logic [AW-1:0]     prev_row = '0, prev_addr = '0;
    logic              prev_last = 1'b0;
    start     = 1'b1;
    base_addr = base;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_c1", busy, 1);
      if (cyc == 1 || rd_address != prev_addr) begin
        if (naddr < MS) chk("rd_addr", rd_address, AW'(base + naddr));
        naddr++;
      end
      prev_addr = rd_address;
      if (out_valid && first_v == 0) first_v = cyc;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_row", out_row, prev_row);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        chk("beat_data", out_data, exp_beat(base, nbeat));
        chk("beat_row", out_row, AW'(nbeat / BPR));
        chk("beat_last", out_last, nbeat == NB - 1);
        nbeat++;
        last_hs = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk("done_after_last", cyc, last_hs + 1);
        chk("busy_at_done", busy, 1);
      end else if (done_cyc != 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", busy, 0);
        fin = 1;
      end
      if (cyc > 3000) begin
        chk("drain_timeout", cyc, EXP_DONE);
        fin = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_row   = out_row;
      prev_last  = out_last;
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = pulses && (cyc == 49 || cyc == 199);
      if (start) base_addr = AW'($urandom);
      if (!fin && abort_at > 0 && nbeat == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        repeat (4) begin
          @(negedge clk);
          chk("no_done_abort", done, 0);
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        aborted = 1;
        fin     = 1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("addr_count", naddr, MS);
      chk("beat_count", nbeat, NB);
      chk("done_count", ndone, 1);
      if (!rnd) begin
        chk("first_valid_cycle", first_v, 3);
        chk("done_cycle", done_cyc, EXP_DONE);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    fill_pattern();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_drain(10'd0, 1'b0, 1'b0, 0);
    run_drain(10'd0, 1'b1, 1'b0, 0);
    fill_random();
    run_drain(10'd1020, 1'b0, 1'b0, 0);
    run_drain(10'd0, 1'b0, 1'b1, 0);
    run_drain(10'd0, 1'b1, 1'b0, 100);
    fill_random();
    run_drain(AW'($urandom), 1'b1, 1'b0, 0);
    run_drain(10'd5, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
